// File: rtl/serial_pkg.sv
// Shared definitions for the serial line stages: receiver state encoding and line-level constants.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic LINE_IDLE = 1'b0;
    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    localparam int unsigned DEFAULT_DATA_W = 8;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Line-side inputs and parallel-side outputs of the serial frame receiver.
interface serial_frame_receiver_if #(
    parameter int unsigned DATA_W = serial_pkg::DEFAULT_DATA_W
);
    logic              clr;
    logic              bit_en;
    logic              serial_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output clr,
        output bit_en,
        output serial_in,
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  clr,
        input  bit_en,
        input  serial_in,
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/rx_bit_counter.sv
// Loadable, enable-gated data bit counter; saturates at DATA_W-1 and flags terminal count.
module rx_bit_counter #(
    parameter int unsigned DATA_W = serial_pkg::DEFAULT_DATA_W,
    parameter int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc  = (cnt_q == CNT_W'(DATA_W - 1));
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && !tc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/serial_frame_receiver.sv
// Receives start / DATA_W data bits MSB-first / even parity / stop frames and presents each word
// with a one-cycle valid strobe and per-frame error flags.
module serial_frame_receiver
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input logic                    clk,
    input logic                    rst,
    serial_frame_receiver_if.slave bus
);
    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d;
    logic              par_bad_q, par_bad_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;

    logic             cnt_load;
    logic             cnt_en;
    logic [CNT_W-1:0] bit_cnt;
    logic             cnt_tc;

    rx_bit_counter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val ('0),
        .en       (cnt_en),
        .cnt      (bit_cnt),
        .tc       (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        par_bad_d = par_bad_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;

        // clr outranks bit_en, so a stop bit coinciding with clr yields no strobe at all
        if (bus.clr) begin
            state_d  = IDLE;
            cnt_load = 1'b1;
        end else if (bus.bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.serial_in == START_BIT) begin
                        state_d  = DATA;
                        cnt_load = 1'b1;
                        par_d    = 1'b0;
                    end
                end
                DATA: begin
                    shreg_d = {shreg_q[DATA_W-2:0], bus.serial_in};
                    par_d   = par_q ^ bus.serial_in;
                    if (cnt_tc) begin
                        state_d = PARITY;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                PARITY: begin
                    par_bad_d = par_q ^ bus.serial_in;
                    state_d   = STOP;
                end
                STOP: begin
                    if (bus.serial_in == STOP_BIT) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        perr_d  = par_bad_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            par_bad_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            par_bad_q <= par_bad_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    logic unused_cnt;
    assign unused_cnt = ^bit_cnt;

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Self-checking bench: frames are built bit by bit and outcomes predicted from frame contents.
module tb_serial_frame_receiver;
    import serial_pkg::*;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_data = '0;

    serial_frame_receiver_if #(.DATA_W(W)) bus ();

    serial_frame_receiver #(
        .DATA_W (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic ev, input logic ep, input logic ef, input logic eb);
        check_eq("data_valid", 32'(bus.data_valid), 32'(ev));
        check_eq("parity_err", 32'(bus.parity_err), 32'(ep));
        check_eq("frame_err",  32'(bus.frame_err),  32'(ef));
        check_eq("busy",       32'(bus.busy),       32'(eb));
        check_eq("data_out",   32'(bus.data_out),   32'(exp_data));
    endtask

    // Drive one cycle, then check outputs just after the sampling edge.
    task automatic cycle(input logic en, input logic sin, input logic clr,
                         input logic ev, input logic ep, input logic ef, input logic eb);
        bus.bit_en    = en;
        bus.serial_in = sin;
        bus.clr       = clr;
        @(posedge clk);
        #1;
        check_outputs(ev, ep, ef, eb);
    endtask

    // Send one frame; stall_pct sets the chance of a disabled cycle before each bit.
    task automatic send_frame(input logic [W-1:0] word, input logic bad_par,
                              input logic bad_stop, input int unsigned stall_pct,
                              input logic clr_at_stop);
        logic bits[$];
        int   last;
        bits.push_back(START_BIT);
        for (int i = W - 1; i >= 0; i--) bits.push_back(word[i]);
        bits.push_back((^word) ^ bad_par);
        bits.push_back(bad_stop ? 1'b1 : STOP_BIT);
        last = bits.size() - 1;
        for (int i = 0; i <= last; i++) begin
            while ($urandom_range(99) < stall_pct) begin
                cycle(1'b0, 1'($urandom_range(1)), 1'b0, 1'b0, 1'b0, 1'b0, i > 0);
            end
            if (i < last) begin
                cycle(1'b1, bits[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end else if (clr_at_stop) begin
                cycle(1'b1, bits[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            end else if (!bad_stop) begin
                exp_data = word;
                cycle(1'b1, bits[i], 1'b0, 1'b1, bad_par, 1'b0, 1'b0);
            end else begin
                cycle(1'b1, bits[i], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
        end
    endtask

    initial begin
        bus.clr       = 1'b0;
        bus.bit_en    = 1'b0;
        bus.serial_in = LINE_IDLE;
        repeat (2) @(posedge clk);
        #1;
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Good frame, parity error, frame error
        send_frame(8'hA5, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b1, LINE_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0);
        cycle(1'b1, LINE_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b0);
        // The 1 in the stop slot must not start a new frame
        cycle(1'b1, LINE_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Stalled frame followed back-to-back by an unstalled one
        send_frame(8'h81, 1'b0, 1'b0, 50, 1'b0);
        send_frame(8'h7E, 1'b0, 1'b0, 0, 1'b0);

        // Reset after four data bits of 0xFF
        cycle(1'b1, START_BIT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        #2;
        exp_data = '0;
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, LINE_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort with clr on the stop bit: data_out must keep the earlier word
        send_frame(8'h5A, 1'b0, 1'b0, 0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0, 0, 1'b1);
        cycle(1'b1, LINE_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Idle noise
        for (int i = 0; i < 20; i++) cycle(1'b1, LINE_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized frames with random faults, stalls and gaps
        for (int n = 0; n < 40; n++) begin
            send_frame(W'($urandom), 1'($urandom_range(3) == 0), 1'($urandom_range(4) == 0),
                       $urandom_range(40), 1'($urandom_range(7) == 0));
            repeat ($urandom_range(2)) begin
                cycle(1'b1, LINE_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
